// File: rtl/ciphertext_fifo_pkg.sv
// rtl/ciphertext_fifo_pkg.sv - shared AES engine constants: buffer geometry and writer FSM encodings
package ciphertext_fifo_pkg;

    localparam int DEPTH       = 32;
    localparam int BLOCK_BYTES = 16;
    localparam int PTR_W       = 6;
    localparam int ADDR_W      = 5;
    localparam int CNT_W       = 4;
    localparam int DATA_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    // Committed occupancy; the wrap bit makes 32 distinguishable from 0.
    function automatic logic [PTR_W-1:0] occupancy(
        input logic [PTR_W-1:0] head,
        input logic [PTR_W-1:0] tail
    );
        return head - tail;
    endfunction

endpackage

// File: rtl/ciphertext_fifo.sv
// rtl/ciphertext_fifo.sv - block-committing ciphertext FIFO: 16-byte blocks become readable only once complete
module ciphertext_fifo
    import ciphertext_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] data_in,
    input  logic       data_ok,
    input  logic       out_ready,
    input  logic       clear_flags,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [1:0] blocks_ready,
    output logic       overflow,
    output logic       frag_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_commit;
    wr_state_e         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_overflow;
    logic              r_frag_err;

    logic [PTR_W-1:0]  w_used;
    logic [PTR_W:0]    w_free;
    logic              w_has_room;
    logic              w_last;
    logic              w_wr_en;
    logic              w_rd_fire;
    logic              w_set_ovf;
    logic              w_set_frag;

    // Free space is judged against commit, so bytes of a block still being
    // drained this cycle are counted as occupied until the edge.
    assign w_used     = occupancy(r_commit, r_rd);
    assign w_free     = (PTR_W+1)'(DEPTH) - {1'b0, w_used};
    assign w_has_room = (w_free >= (PTR_W+1)'(BLOCK_BYTES));
    assign w_last     = (r_cnt == CNT_W'(BLOCK_BYTES - 1));

    assign w_wr_en    = data_ok && (((r_state == ST_IDLE) && w_has_room) ||
                                    (r_state == ST_FILL));
    assign w_set_ovf  = data_ok && (r_state == ST_IDLE) && !w_has_room;
    assign w_set_frag = !data_ok && (r_state == ST_FILL);

    assign out_valid    = (r_rd != r_commit);
    assign w_rd_fire    = out_valid && out_ready;
    assign out_data     = out_valid ? r_mem[r_rd[ADDR_W-1:0]] : 8'h00;
    assign blocks_ready = 2'(({1'b0, w_used} + (PTR_W+1)'(BLOCK_BYTES - 1)) >> 4);
    assign overflow     = r_overflow;
    assign frag_err     = r_frag_err;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd <= '0;
        end else if (w_rd_fire) begin
            r_rd <= r_rd + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wr       <= '0;
            r_commit   <= '0;
            r_overflow <= 1'b0;
            r_frag_err <= 1'b0;
        end else begin
            r_overflow <= w_set_ovf  | (r_overflow & ~clear_flags);
            r_frag_err <= w_set_frag | (r_frag_err & ~clear_flags);
            case (r_state)
                ST_IDLE: begin
                    if (data_ok) begin
                        r_cnt <= CNT_W'(1);
                        if (w_has_room) begin
                            r_wr    <= r_wr + PTR_W'(1);
                            r_state <= ST_FILL;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_FILL: begin
                    if (data_ok) begin
                        r_wr  <= r_wr + PTR_W'(1);
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_commit <= r_wr + PTR_W'(1);
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        // Short block: roll the writer back so the fragment vanishes.
                        r_wr    <= r_commit;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (data_ok && !w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ciphertext_fifo.md
CIPHERTEXT_FIFO -- requirements
Module: ciphertext_fifo

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_  in  1  asynchronous, active-low reset.
- data_in  in  8  ciphertext byte from the output interface.
- data_ok  in  1  high = data_in carries one valid byte this cycle.
- out_ready  in  1  downstream accepts out_data this cycle.
- clear_flags  in  1  synchronous clear of sticky error flags.
- out_data  out  8  head byte of committed data; 8'h00 when out_valid low.
- out_valid  out  1  at least one committed byte is available.
- blocks_ready  out  2  number of complete committed 16-byte blocks not yet fully drained (0..2).
- overflow  out  1  sticky: a block was dropped for lack of space.
- frag_err  out  1  sticky: a block ended before 16 bytes.
REQ-002 SHALL use only the clock and reset named above; the reset is asynchronous and active-low (fixed).

Function
REQ-003 SHALL store bytes in a 32-entry x 8-bit buffer (two AES blocks), with 6-bit read, write and commit pointers (5-bit address plus wrap bit).
REQ-004 SHALL expose to the reader only bytes below the commit pointer; uncommitted bytes SHALL never appear on out_data.
REQ-005 SHALL run a writer FSM with states IDLE, FILL and DROP; cnt is a 4-bit byte counter.
REQ-006 In IDLE with data_ok=1: if free space (32 - (commit - rd)) >= 16, SHALL write the byte, set cnt=1 and enter FILL; otherwise SHALL set overflow, set cnt=1 and enter DROP.
REQ-007 In FILL with data_ok=1: SHALL write the byte and increment cnt; on the 16th byte SHALL advance commit to wr+1 in the same edge and return to IDLE.
REQ-008 In FILL with data_ok=0: SHALL restore wr to commit, set frag_err and return to IDLE.
REQ-009 In DROP: SHALL discard bytes and count them; SHALL return to IDLE after the 16th byte, or immediately when data_ok=0.
REQ-010 Read handshake: a byte transfers when out_valid and out_ready are both high; rd SHALL increment on that edge. out_data SHALL be a combinational read of mem[rd].
REQ-011 Simultaneous write, commit and read in one cycle SHALL all take effect; the free-space check SHALL use pre-edge pointer values.
REQ-012 Pointers SHALL wrap modulo 64; full = 32 committed-or-pending bytes, empty = (rd == commit).
REQ-013 blocks_ready SHALL equal ceil((commit - rd) / 16).
REQ-014 clear_flags SHALL clear overflow and frag_err; a set event in the same cycle SHALL win.
REQ-015 The FSM SHALL NOT depend on the gap between blocks; back-to-back 16-byte bursts SHALL be accepted when space allows.

Reset
REQ-016 While rst_=0: all pointers 0; state IDLE; cnt 0; out_valid 0; out_data 8'h00; blocks_ready 0; overflow 0; frag_err 0. Buffer contents are not reset.
REQ-017 Reset asserted mid-FILL SHALL discard the partial block; no flag SHALL be raised by the reset itself.

Structure
REQ-018 SHALL place DEPTH=32, BLOCK_BYTES=16, pointer width 6 and the state encodings in the shared AES engine constants package.
REQ-019 SHALL be one module with no sub-modules; the buffer is a flop array inside it.

Verification
REQ-020 One 16-byte burst 8'h00..8'h0F with out_ready=0 -> out_valid rises the cycle after the 16th byte, blocks_ready=1; then out_ready=1 drains 00..0F in order, out_valid falls after byte 0F.
REQ-021 Two bursts with out_ready=0 -> blocks_ready=2; third burst -> overflow=1, buffer unchanged, both blocks drain intact.
REQ-022 data_ok drops after 9 bytes -> frag_err=1, out_valid stays 0, blocks_ready=0; next 16-byte burst drains correctly.
REQ-023 out_ready=1 held while a second burst writes during drain of the first -> 32 bytes emerge in order, no flags, pointers wrap cleanly past 63.
REQ-024 rst_ pulsed low asynchronously after 5 bytes of a burst -> all outputs at reset values immediately; a following full burst drains correctly.
REQ-025 clear_flags pulse with both flags set -> both 0 next cycle; clear_flags coincident with a new overflow -> overflow stays 1.
